// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS control FSM; optional MUL stall under MUL_STALL_EN
module mc_controller #(
    parameter int MUL_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MUL  = 6'b011100;

    // The counter is 4 bits wide, so the latency must fit 1..15.
    if (MUL_LATENCY < 1 || MUL_LATENCY > 15) begin : g_bad_mul_latency
        $error("MUL_LATENCY must be in 1..15");
    end

    state_t cur_state;
    state_t nxt_state;
    logic   pcwrite;
    logic   branch;
    logic   irwrite_raw;
    logic   memwrite_raw;
    logic   regwrite_raw;

`ifdef MUL_STALL_EN
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);
    logic [3:0] mul_cnt;

    // Preload the MUL countdown while decoding so EXEC sees it on its first cycle.
    always_ff @(posedge clk) begin
        if (rst)
            mul_cnt <= 4'd0;
        else if (cur_state == DECODE)
            mul_cnt <= MUL_LOAD;
        else if (cur_state == EXEC && mul_cnt != 4'd0)
            mul_cnt <= mul_cnt - 4'd1;
    end
`endif

    // State register; reset lands in FETCH from anywhere.
    always_ff @(posedge clk) begin
        if (rst)
            cur_state <= FETCH;
        else
            cur_state <= nxt_state;
    end

    // Next-state and control decode; every output defaults to its idle value first.
    always_comb begin
        nxt_state    = FETCH;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        iord         = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        ALUControl   = 3'b010;
        case (cur_state)
            FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = mem_ready;
                pcwrite     = mem_ready;
                nxt_state   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: nxt_state = MEMADR;
                    OP_R:         nxt_state = EXEC;
                    OP_ADDI:      nxt_state = ADDIEX;
                    OP_BEQ:       nxt_state = BEQ;
                    OP_J:         nxt_state = JUMP;
                    default:      nxt_state = FETCH;
                endcase
            end
            MEMADR: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                nxt_state = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord      = 1'b1;
                nxt_state = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regwrite_raw = 1'b1;
                memtoreg     = 1'b1;
            end
            MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
                nxt_state    = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alusrca   = 1'b1;
                nxt_state = ALUWB;
                case (funct)
                    FN_ADD:  ALUControl = 3'b010;
                    FN_SUB:  ALUControl = 3'b100;
                    FN_SLT:  ALUControl = 3'b110;
                    FN_MUL:  ALUControl = 3'b101;
                    default: ALUControl = 3'b010;
                endcase
`ifdef MUL_STALL_EN
                if (funct == FN_MUL && mul_cnt != 4'd0)
                    nxt_state = EXEC;
`endif
            end
            ALUWB: begin
                regwrite_raw = 1'b1;
                regdst       = 1'b1;
            end
            ADDIEX: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                nxt_state = ADDIWB;
            end
            ADDIWB: begin
                regwrite_raw = 1'b1;
            end
            BEQ: begin
                alusrca    = 1'b1;
                ALUControl = 3'b100;
                branch     = 1'b1;
                pcsrc      = 2'b01;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: nxt_state = FETCH;
        endcase
    end

    assign pc_en    = ~rst & (pcwrite | (branch & zero));
    assign irwrite  = ~rst & irwrite_raw;
    assign memwrite = ~rst & memwrite_raw;
    assign regwrite = ~rst & regwrite_raw;
    assign state    = cur_state;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - trace-model checker for mc_controller
module tb_mc_controller;

    localparam int MUL_LAT = 4;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                   S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7, S_BEQ = 8, S_ADDIEX = 9,
                   S_ADDIWB = 10, S_JUMP = 11;

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                           OP_ADDI = 6'b001000, OP_BEQ = 6'b000100, OP_J = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_SLT = 6'b101010,
                           FN_MUL = 6'b011100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, irwrite, memwrite, regwrite, iord, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    always #5 clk = ~clk;

    mc_controller #(.MUL_LATENCY(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .irwrite(irwrite), .memwrite(memwrite),
        .regwrite(regwrite), .iord(iord), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .ALUControl(ALUControl),
        .state(state)
    );

    logic [14:0] dut_vec;
    assign dut_vec = {pc_en, irwrite, memwrite, regwrite, iord, regdst, memtoreg,
                      alusrca, alusrcb, pcsrc, ALUControl};

    typedef struct {
        bit       rst;
        bit       chk;
        logic [5:0] op;
        logic [5:0] fn;
        bit       z;
        bit       mr;
        int       st;
    } ent_t;

    ent_t       q[$];
    int         obs_state[$];
    int         obs_memwrite;
    int         checks = 0;
    int         errors = 0;
    logic [5:0] cur_op;
    logic [5:0] cur_fn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int exec_cycles(input logic [5:0] fn);
`ifdef MUL_STALL_EN
        return (fn == FN_MUL) ? MUL_LAT : 1;
`else
        return 1;
`endif
    endfunction

    // What the outputs must be in a given phase of an instruction.
    function automatic logic [14:0] exp_out(input int st, input logic [5:0] fn,
                                            input bit z, input bit mr, input bit r);
        bit pce = 0, irw = 0, mw = 0, rw = 0, io = 0, rd = 0, m2r = 0, asa = 0;
        logic [1:0] asb = 2'b00, ps = 2'b00;
        logic [2:0] alu = 3'b010;
        case (st)
            S_FETCH:  begin asb = 2'b01; irw = mr; pce = mr; end
            S_DECODE: asb = 2'b11;
            S_MEMADR: begin asa = 1; asb = 2'b10; end
            S_MEMRD:  io = 1;
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin io = 1; mw = 1; end
            S_EXEC: begin
                asa = 1;
                if (fn == FN_SUB) alu = 3'b100;
                else if (fn == FN_SLT) alu = 3'b110;
                else if (fn == FN_MUL) alu = 3'b101;
            end
            S_ALUWB:  begin rw = 1; rd = 1; end
            S_ADDIEX: begin asa = 1; asb = 2'b10; end
            S_ADDIWB: rw = 1;
            S_BEQ:    begin asa = 1; alu = 3'b100; ps = 2'b01; pce = z; end
            S_JUMP:   begin ps = 2'b10; pce = 1; end
            default:  ;
        endcase
        if (r) begin pce = 0; irw = 0; mw = 0; rw = 0; end
        return {pce, irw, mw, rw, io, rd, m2r, asa, asb, ps, alu};
    endfunction

    task automatic push(input int st, input bit mr, input bit r, input bit c);
        ent_t e;
        e.rst = r; e.chk = c; e.op = cur_op; e.fn = cur_fn;
        e.z = rnd(); e.mr = mr; e.st = st;
        q.push_back(e);
    endtask

    // Expand one instruction into its expected per-cycle phase list.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int nf, input int nm, output int len);
        int n0 = q.size();
        cur_op = op; cur_fn = fn;
        repeat (nf) push(S_FETCH, 0, 0, 1);
        push(S_FETCH, 1, 0, 1);
        push(S_DECODE, rnd(), 0, 1);
        case (op)
            OP_LW: begin
                push(S_MEMADR, rnd(), 0, 1);
                repeat (nm) push(S_MEMRD, 0, 0, 1);
                push(S_MEMRD, 1, 0, 1);
                push(S_MEMWB, rnd(), 0, 1);
            end
            OP_SW: begin
                push(S_MEMADR, rnd(), 0, 1);
                repeat (nm) push(S_MEMWR, 0, 0, 1);
                push(S_MEMWR, 1, 0, 1);
            end
            OP_R: begin
                repeat (exec_cycles(fn)) push(S_EXEC, rnd(), 0, 1);
                push(S_ALUWB, rnd(), 0, 1);
            end
            OP_ADDI: begin
                push(S_ADDIEX, rnd(), 0, 1);
                push(S_ADDIWB, rnd(), 0, 1);
            end
            OP_BEQ: push(S_BEQ, rnd(), 0, 1);
            OP_J:   push(S_JUMP, rnd(), 0, 1);
            default: ;
        endcase
        len = q.size() - n0;
    endtask

    // Drive each queued cycle at the falling edge and compare once outputs settle.
    task automatic flush();
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst = e.rst; opcode = e.op; funct = e.fn; zero = e.z; mem_ready = e.mr;
            #1;
            obs_state.push_back(int'(state));
            if (memwrite === 1'b1) obs_memwrite++;
            if (e.chk) begin
                check("state", 32'(state), 32'(e.st));
                check("outputs", 32'(dut_vec), 32'(exp_out(e.st, e.fn, e.z, e.mr, e.rst)));
            end
        end
    endtask

    initial begin
        int len;
        int lw_exp[5] = '{0, 1, 2, 3, 4};
        int mul_len;
        logic [5:0] ops[6] = '{OP_LW, OP_SW, OP_R, OP_ADDI, OP_BEQ, OP_J};
        logic [5:0] fns[4] = '{FN_ADD, FN_SUB, FN_SLT, FN_MUL};
        logic [5:0] op, fn;

`ifdef MUL_STALL_EN
        mul_len = 7;
`else
        mul_len = 4;
`endif

        // Reset for two cycles; the second one must already sit in FETCH with strobes low.
        cur_op = OP_LW; cur_fn = 6'd0;
        push(S_FETCH, 1, 1, 0);
        push(S_FETCH, 1, 1, 1);
        flush();

        // lw, no stalls: state walk 0,1,2,3,4.
        obs_state.delete();
        run_instr(OP_LW, FN_ADD, 0, 0, len);
        check("len_lw", 32'(len), 32'd5);
        flush();
        for (int i = 0; i < 5; i++) check("lw_state_seq", 32'(obs_state[i]), 32'(lw_exp[i]));

        // sw with three stall cycles in MEMWR: memwrite for four cycles.
        obs_memwrite = 0;
        run_instr(OP_SW, FN_ADD, 0, 3, len);
        check("len_sw_stall", 32'(len), 32'd7);
        flush();
        check("sw_memwrite_cycles", 32'(obs_memwrite), 32'd4);

        run_instr(OP_SW, FN_ADD, 0, 0, len);
        check("len_sw", 32'(len), 32'd4);
        flush();

        run_instr(OP_R, FN_SLT, 0, 0, len);
        check("len_slt", 32'(len), 32'd4);
        flush();

        run_instr(OP_ADDI, FN_ADD, 0, 0, len);
        check("len_addi", 32'(len), 32'd4);
        flush();

        // beq taken then not taken.
        run_instr(OP_BEQ, FN_ADD, 0, 0, len);
        check("len_beq", 32'(len), 32'd3);
        q[q.size() - 1].z = 1'b1;
        flush();
        run_instr(OP_BEQ, FN_ADD, 0, 0, len);
        q[q.size() - 1].z = 1'b0;
        flush();

        run_instr(OP_J, FN_ADD, 1, 0, len);
        check("len_j_fetch_stall", 32'(len), 32'd4);
        flush();

        // Unknown opcode behaves as a NOP.
        run_instr(6'b111111, FN_ADD, 0, 0, len);
        check("len_nop", 32'(len), 32'd2);
        flush();

        run_instr(OP_R, FN_MUL, 0, 0, len);
        check("len_mul", 32'(len), 32'(mul_len));
        flush();

        // Reset asserted while lw is waiting in MEMRD.
        cur_op = OP_LW; cur_fn = FN_ADD;
        push(S_FETCH, 1, 0, 1);
        push(S_DECODE, 1, 0, 1);
        push(S_MEMADR, 1, 0, 1);
        push(S_MEMRD, 0, 0, 1);
        push(S_MEMRD, 0, 1, 1);
        flush();

        // Randomized instruction stream with random stalls.
        for (int n = 0; n < 200; n++) begin
            int k = $urandom_range(0, 6);
            int j = $urandom_range(0, 4);
            op = (k == 6) ? 6'($urandom) : ops[k];
            fn = (j == 4) ? 6'($urandom) : fns[j];
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), len);
            flush();
        end

        // Final landing in FETCH.
        cur_op = 6'b111111;
        push(S_FETCH, 0, 0, 1);
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control FSM for the MIPS core: sequences one shared ALU, a unified instruction/data memory and the register file across several cycles per instruction.
- Replaces the single-cycle main/ALU decoder pair in the multicycle datapath variant.
- Decodes opcode/funct latched in the instruction register.
- Handles a memory ready handshake and the branch-taken PC enable.

Parameters:
- MUL_LATENCY, 4, number of EXEC cycles held for MUL (funct 6'b011100); used only when the optional feature is compiled in; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  6  instr[31:26] from the instruction register
- funct  input  6  instr[5:0] from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- pc_en  output  1  PC load enable = pcwrite | (branch & zero)
- irwrite  output  1  instruction register load
- memwrite  output  1  memory write request
- regwrite  output  1  register file write
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- regdst  output  1  write register select: 1 = rd, 0 = rt
- memtoreg  output  1  writeback select: 1 = Data register, 0 = ALUOut
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  output  2  ALU B select: 00 = register B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  output  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- ALUControl  output  3  010 add, 100 sub, 110 slt, 101 mul
- state  output  4  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- State register is updated on the clk rising edge. Outputs are a combinational decode of state, plus funct in EXEC and mem_ready in the memory states.
- Reset:
  - rst=1 at an edge sets state to FETCH and clears the MUL counter, from any state, including mid-wait.
  - While rst=1, pc_en, irwrite, memwrite and regwrite are forced to 0.
- Default in every state: all strobes 0, selects 0, ALUControl=010.
- FETCH:
  - Outputs: iord=0, alusrca=0, alusrcb=01, pcsrc=00, ALUControl=010.
  - irwrite = pcwrite = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, ALUControl=010 (branch target into ALUOut).
  - Next state by opcode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 001000 -> ADDIEX; 000100 -> BEQ; 000010 -> JUMP; any other opcode -> FETCH (treated as a NOP).
- MEMADR:
  - Outputs: alusrca=1, alusrcb=10, ALUControl=010.
  - Next state: lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1. Next state FETCH.
- MEMWR:
  - Outputs: iord=1; memwrite=1 held for every cycle until mem_ready=1.
  - Goes to FETCH in the cycle after mem_ready=1 is seen.
- EXEC:
  - Outputs: alusrca=1, alusrcb=00.
  - ALUControl by funct: 100000 -> 010, 100010 -> 100, 101010 -> 110, 011100 -> 101, other -> 010.
  - Next state ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0. Next state FETCH.
- ADDIEX: alusrca=1, alusrcb=10, ALUControl=010. Next state ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. Next state FETCH.
- BEQ:
  - Outputs: alusrca=1, alusrcb=00, ALUControl=100, branch=1, pcsrc=01.
  - pc_en = zero.
  - Next state FETCH.
- JUMP: pcsrc=10, pcwrite=1. Next state FETCH.
- Latency with mem_ready tied high:
  - lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
  - Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Unreachable state codes 12..15 go to FETCH on the next edge, with all strobes 0.

Optional Feature:
- Macro: MUL_STALL_EN.
- Defined:
  - EXEC with funct 011100 loads a 4-bit counter with MUL_LATENCY-1 and stays in EXEC until the counter reaches 0, decrementing each cycle.
  - ALUControl=101 is held throughout; then goes to ALUWB.
  - Result: MUL takes 3+MUL_LATENCY cycles.
  - rst clears the counter.
- Not defined: MUL takes one EXEC cycle like other R-type instructions, and no counter is present.

Test Plan:
- rst=1 for 2 cycles, then rst=0, mem_ready=1, opcode=100011 (lw) -> state sequence 0,1,2,3,4,0; pc_en=1 in FETCH only; regwrite=1 and memtoreg=1 in state 4.
- sw with mem_ready=0 for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then state 0; regwrite never 1.
- R-type funct 101010 -> ALUControl=110 in EXEC; regwrite=1 and regdst=1 in ALUWB; 4 cycles total.
- beq: zero=1 -> pc_en=1 and pcsrc=01 in state 8. Repeat with zero=0 -> pc_en=0; both return to FETCH.
- Opcode 111111 -> FETCH, DECODE, FETCH with no strobes in DECODE. Assert rst in MEMRD while mem_ready=0 -> state 0 on the next edge, with regwrite and memwrite 0.
- With MUL_STALL_EN and MUL_LATENCY=4, funct 011100 -> EXEC held 4 cycles with ALUControl=101, then ALUWB; 7 cycles total. Without the macro -> 4 cycles total.
